// File: rtl/alu32_exec_unit_if.sv
// Operand/result bundle for the 32-bit execute-stage ALU and its free-standing adder.
// The master drives operands and opcode fields; the slave (the ALU) returns results.
interface alu32_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [4:0]       shamt;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;

  modport master (
    output alu_op, funct, data1, data2, shamt, add_a, add_b,
    input  alu_ctrl, result, zero, overflow, add_sum
  );

  modport slave (
    input  alu_op, funct, data1, data2, shamt, add_a, add_b,
    output alu_ctrl, result, zero, overflow, add_sum
  );
endinterface

// File: rtl/alu32_exec_unit.sv
// Execute-stage ALU: combinational control decode, registered result/zero/overflow
// (one-cycle latency) and an independent combinational adder.
module alu32_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu32_exec_unit_if.slave  bus
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_NOR  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_LUI  = 4'b1100;
  localparam logic [3:0] C_ADDU = 4'b1101;
  localparam logic [3:0] C_SUBU = 4'b1110;

  logic [3:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;

  always_comb begin
    w_alu_ctrl = C_ADD;
    case (bus.alu_op)
      4'b0000: w_alu_ctrl = C_ADD;
      4'b0001: w_alu_ctrl = C_SUB;
      4'b0010: begin
        case (bus.funct)
          6'h20:   w_alu_ctrl = C_ADD;
          6'h21:   w_alu_ctrl = C_ADDU;
          6'h22:   w_alu_ctrl = C_SUB;
          6'h23:   w_alu_ctrl = C_SUBU;
          6'h24:   w_alu_ctrl = C_AND;
          6'h25:   w_alu_ctrl = C_OR;
          6'h26:   w_alu_ctrl = C_XOR;
          6'h27:   w_alu_ctrl = C_NOR;
          6'h2A:   w_alu_ctrl = C_SLT;
          6'h2B:   w_alu_ctrl = C_SLTU;
          6'h00:   w_alu_ctrl = C_SLL;
          6'h02:   w_alu_ctrl = C_SRL;
          6'h03:   w_alu_ctrl = C_SRA;
          default: w_alu_ctrl = C_ADD;
        endcase
      end
      4'b0011: w_alu_ctrl = C_AND;
      4'b0100: w_alu_ctrl = C_OR;
      4'b0101: w_alu_ctrl = C_XOR;
      4'b0110: w_alu_ctrl = C_SLT;
      4'b0111: w_alu_ctrl = C_SLTU;
      4'b1000: w_alu_ctrl = C_LUI;
      default: w_alu_ctrl = C_ADD;
    endcase
  end

  assign w_sum  = bus.data1 + bus.data2;
  assign w_diff = bus.data1 - bus.data2;

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (w_alu_ctrl)
      C_ADD: begin
        w_result   = w_sum;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        w_overflow = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      C_ADDU: w_result = w_sum;
      C_SUB: begin
        w_result   = w_diff;
        w_overflow = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      C_SUBU: w_result = w_diff;
      C_AND:  w_result = bus.data1 & bus.data2;
      C_OR:   w_result = bus.data1 | bus.data2;
      C_XOR:  w_result = bus.data1 ^ bus.data2;
      C_NOR:  w_result = ~(bus.data1 | bus.data2);
      C_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
      C_SLTU: w_result = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
      C_SLL:  w_result = bus.data2 << bus.shamt;
      C_SRL:  w_result = bus.data2 >> bus.shamt;
      C_SRA:  w_result = $signed(bus.data2) >>> bus.shamt;
      C_LUI:  w_result = {bus.data2[15:0], {(WIDTH-16){1'b0}}};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_zero     <= (w_result == '0);
      r_overflow <= w_overflow;
    end
  end

  assign bus.alu_ctrl = w_alu_ctrl;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_overflow;
  assign bus.add_sum  = bus.add_a + bus.add_b;

endmodule

// File: tb/tb_alu32_exec_unit.sv
// Scoreboard bench for alu32_exec_unit: expected captures queued at drive time,
// popped and compared one cycle later; directed vectors then randomized ones.
module tb_alu32_exec_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  alu32_exec_unit_if #(.WIDTH(32)) bus ();

  alu32_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_ctrl(input logic [3:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = 4'b0010;
    if (op == 4'b0010) begin
      case (fn)
        6'h20: c = 4'b0010;  6'h21: c = 4'b1101;  6'h22: c = 4'b0110;
        6'h23: c = 4'b1110;  6'h24: c = 4'b0000;  6'h25: c = 4'b0001;
        6'h26: c = 4'b0011;  6'h27: c = 4'b0100;  6'h2A: c = 4'b0111;
        6'h2B: c = 4'b1000;  6'h00: c = 4'b1001;  6'h02: c = 4'b1010;
        6'h03: c = 4'b1011;  default: c = 4'b0010;
      endcase
    end else begin
      case (op)
        4'b0001: c = 4'b0110;  4'b0011: c = 4'b0000;  4'b0100: c = 4'b0001;
        4'b0101: c = 4'b0011;  4'b0110: c = 4'b0111;  4'b0111: c = 4'b1000;
        4'b1000: c = 4'b1100;  default: c = 4'b0010;
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'b0010, 4'b1101: t = 64'(a) + 64'(b);
      4'b0110, 4'b1110: t = 64'(a) - 64'(b);
      4'b0000: t = {32'h0, a & b};
      4'b0001: t = {32'h0, a | b};
      4'b0011: t = {32'h0, a ^ b};
      4'b0100: t = {32'h0, ~(a | b)};
      4'b0111: t = (sa < sb) ? 64'd1 : 64'd0;
      4'b1000: t = (a < b) ? 64'd1 : 64'd0;
      4'b1001: t = 64'(b) << sh;
      4'b1010: t = 64'(b) >> sh;
      4'b1011: t = 64'(sb >>> sh);
      4'b1100: t = {32'h0, b[15:0], 16'h0};
      default: t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  function automatic logic model_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (c == 4'b0010)      s = longint'($signed(a)) + longint'($signed(b));
    else if (c == 4'b0110) s = longint'($signed(a)) - longint'($signed(b));
    else                   return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input string tag, input logic [3:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [3:0] exp_ctrl, input logic [31:0] exp_res, input logic exp_ovf);
    sb_entry_t e;
    bus.alu_op = op;
    bus.funct  = fn;
    bus.data1  = a;
    bus.data2  = b;
    bus.shamt  = sh;
    sb_q.push_back('{tag, exp_res, exp_ovf});
    #1;
    check({tag, ".ctrl"}, {28'h0, bus.alu_ctrl}, {28'h0, exp_ctrl});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".result"}, bus.result, e.res);
      check({e.tag, ".zero"}, {31'h0, bus.zero}, {31'h0, (e.res == 32'h0)});
      check({e.tag, ".ovf"}, {31'h0, bus.overflow}, {31'h0, e.ovf});
    end
    $display("vec %-10s op=%b fn=%h a=%h b=%h sh=%0d -> ctrl=%b res=%h z=%b v=%b",
             tag, op, fn, a, b, sh, bus.alu_ctrl, bus.result, bus.zero, bus.overflow);
    @(negedge clk);
  endtask

  task automatic apply_model(input string tag, input logic [3:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [3:0] c;
    c = model_ctrl(op, fn);
    apply(tag, op, fn, a, b, sh, c, model_res(c, a, b, sh), model_ovf(c, a, b));
  endtask

  logic [5:0]  fn_tab [16];
  logic [31:0] edge_tab [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    fn_tab   = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h01, 6'h3F, 6'h28};
    edge_tab = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000010};

    reset      = 1'b1;
    bus.alu_op = 4'b0000;
    bus.funct  = 6'h20;
    bus.data1  = 32'd5;
    bus.data2  = 32'd7;
    bus.shamt  = 5'd0;
    bus.add_a  = 32'h00400000;
    bus.add_b  = 32'd4;
    #1 reset = 1'b0;
    #1;
    check("rst.result", bus.result, 32'h0);
    check("rst.zero", {31'h0, bus.zero}, 32'h0);
    check("rst.ovf", {31'h0, bus.overflow}, 32'h0);
    check("adder.same_cycle", bus.add_sum, 32'h00400004);
    bus.add_a = 32'hFFFFFFFC;
    #1;
    check("adder.wrap", bus.add_sum, 32'h0);

    @(negedge clk);
    check("rst.hold_edge", bus.result, 32'h0);
    reset = 1'b1;
    apply("rst_release", 4'b0000, 6'h00, 32'd5, 32'd7, 5'd0, 4'b0010, 32'd12, 1'b0);

    apply("rtype_sub", 4'b0010, 6'h22, 32'd10, 32'd10, 5'd0, 4'b0110, 32'h0, 1'b0);
    apply("add_ovf", 4'b0000, 6'h00, 32'h7FFFFFFF, 32'h1, 5'd0, 4'b0010, 32'h80000000, 1'b1);
    apply("addu_noovf", 4'b0010, 6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, 4'b1101, 32'h80000000, 1'b0);
    apply("sub_ovf", 4'b0001, 6'h00, 32'h80000000, 32'h1, 5'd0, 4'b0110, 32'h7FFFFFFF, 1'b1);
    apply("subu", 4'b0010, 6'h23, 32'h80000000, 32'h1, 5'd0, 4'b1110, 32'h7FFFFFFF, 1'b0);
    apply("slt", 4'b0110, 6'h00, 32'hFFFFFFFF, 32'h1, 5'd0, 4'b0111, 32'h1, 1'b0);
    apply("sltu", 4'b0111, 6'h00, 32'hFFFFFFFF, 32'h1, 5'd0, 4'b1000, 32'h0, 1'b0);
    apply("sll4", 4'b0010, 6'h00, 32'h0, 32'h80000010, 5'd4, 4'b1001, 32'h00000100, 1'b0);
    apply("srl4", 4'b0010, 6'h02, 32'h0, 32'h80000010, 5'd4, 4'b1010, 32'h08000001, 1'b0);
    apply("sra4", 4'b0010, 6'h03, 32'h0, 32'h80000010, 5'd4, 4'b1011, 32'hF8000001, 1'b0);
    apply("sll0", 4'b0010, 6'h00, 32'h0, 32'h80000010, 5'd0, 4'b1001, 32'h80000010, 1'b0);
    apply("sra31", 4'b0010, 6'h03, 32'h0, 32'h80000010, 5'd31, 4'b1011, 32'hFFFFFFFF, 1'b0);
    apply("srl31", 4'b0010, 6'h02, 32'h0, 32'h80000010, 5'd31, 4'b1010, 32'h00000001, 1'b0);
    apply("nor", 4'b0010, 6'h27, 32'h0F0F0000, 32'h000000F0, 5'd0, 4'b0100, 32'hF0F0FF0F, 1'b0);
    apply("xor", 4'b0101, 6'h00, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 4'b0011, 32'hF00FF00F, 1'b0);
    apply("and", 4'b0011, 6'h00, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 4'b0000, 32'h0F000F00, 1'b0);
    apply("or", 4'b0100, 6'h00, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 4'b0001, 32'hFF0FFF0F, 1'b0);
    apply("lui", 4'b1000, 6'h00, 32'h12345678, 32'h0000ABCD, 5'd0, 4'b1100, 32'hABCD0000, 1'b0);
    apply("op_undef", 4'b1111, 6'h00, 32'd2, 32'd3, 5'd0, 4'b0010, 32'd5, 1'b0);
    apply("fn_undef", 4'b0010, 6'h3F, 32'd2, 32'd3, 5'd0, 4'b0010, 32'd5, 1'b0);

    // Mid-cycle reset: clear must be immediate and the pending capture dropped.
    bus.alu_op = 4'b0000;
    bus.data1  = 32'd3;
    bus.data2  = 32'd4;
    #2 reset = 1'b0;
    #1;
    check("midrst.result", bus.result, 32'h0);
    @(posedge clk);
    #1;
    check("midrst.dropped", bus.result, 32'h0);
    check("midrst.zero", {31'h0, bus.zero}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply("post_rst", 4'b0000, 6'h00, 32'd3, 32'd4, 5'd0, 4'b0010, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = (i % 3 == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      b = (i % 4 == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      apply_model($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                  fn_tab[$urandom_range(0, 15)], a, b, 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      bus.add_a = a;
      bus.add_b = b;
      #1;
      check($sformatf("adder_rnd%0d", i), bus.add_sum, 32'(64'(a) + 64'(b)));
    end

    if (sb_q.size() != 0) check("sb.leftover", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu32_exec_unit.md
ALU32_EXEC_UNIT -- requirements
Module: alu32_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; all values below assume 32.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous reset, active-low.
REQ-005 alu_op  in  4  operation class from the main decoder.
REQ-006 funct  in  6  instruction[5:0], used when alu_op=0010.
REQ-007 data1  in  32  operand A.
REQ-008 data2  in  32  operand B.
REQ-009 shamt  in  5  shift amount.
REQ-010 alu_ctrl  out  4  decoded ALU control, combinational.
REQ-011 result  out  32  registered ALU result.
REQ-012 zero  out  1  registered, 1 when the captured result is 0.
REQ-013 overflow  out  1  registered signed-overflow flag.
REQ-014 add_a, add_b  in  32 each  free-standing adder operands.
REQ-015 add_sum  out  32  combinational add_a+add_b.

Function
REQ-016 The alu_op decode SHALL be:
- 0000 -> ADD(0010)
- 0001 -> SUB(0110)
- 0010 -> funct decode
- 0011 -> AND(0000)
- 0100 -> OR(0001)
- 0101 -> XOR(0011)
- 0110 -> SLT(0111)
- 0111 -> SLTU(1000)
- 1000 -> LUI(1100)
- any other -> ADD.
REQ-017 The funct decode SHALL be:
- 0x20 ADD
- 0x21 ADDU(1101)
- 0x22 SUB
- 0x23 SUBU(1110)
- 0x24 AND
- 0x25 OR
- 0x26 XOR
- 0x27 NOR(0100)
- 0x2A SLT
- 0x2B SLTU
- 0x00 SLL(1001)
- 0x02 SRL(1010)
- 0x03 SRA(1011)
- any other -> ADD.
REQ-018 Results SHALL be:
- ADD/ADDU: A+B mod 2^32
- SUB/SUBU: A-B mod 2^32
- AND, OR, XOR: bitwise
- NOR: ~(A|B)
- SLT: 1 if signed A<B, else 0
- SLTU: 1 if unsigned A<B, else 0
- SLL: B<<shamt
- SRL: B>>shamt, zero-fill
- SRA: B>>shamt, sign-fill
- LUI: {B[15:0],16'h0}
- undefined codes: 0.
REQ-019 overflow SHALL be 1 only for ADD when the operands have equal signs and the sum's sign differs, or for SUB when the operands have different signs and the difference's sign differs from A; it SHALL be 0 for all other operations.
REQ-020 result, zero and overflow SHALL capture the combinational values on every rising clk edge (latency 1 cycle); there is no enable and no handshake.
REQ-021 zero SHALL reflect the result being captured in the same cycle, never the previous one.
REQ-022 On overflow, result SHALL still hold the wrapped sum/difference.
REQ-023 Shift by 0 SHALL return B unchanged; shift by 31 SHALL be supported.
REQ-024 alu_ctrl and add_sum SHALL be purely combinational and unaffected by reset.
REQ-025 add_sum SHALL discard the carry-out, wrapping mod 2^32.

Reset
REQ-026 While reset=0, result SHALL be 0, zero 0 and overflow 0, taking effect immediately without waiting for clk.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight capture.
REQ-028 The first capture after reset SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-029 Reset: hold reset=0 with data1=5, data2=7, ADD -> result=0, zero=0, overflow=0 before any edge; release -> next edge result=12.
REQ-030 R-type: alu_op=0010, funct=0x22, A=10, B=10 -> alu_ctrl=0110; after 1 edge result=0, zero=1.
REQ-031 Overflow: ADD, A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1; same operands with funct 0x21 -> overflow=0.
REQ-032 Compare: A=0xFFFFFFFF, B=1 -> SLT gives 1, SLTU gives 0.
REQ-033 Shifts: B=0x80000010, shamt=4 -> SLL 0x00000100, SRL 0x08000001, SRA 0xF8000001; shamt=0 -> 0x80000010.
REQ-034 Adder: add_a=0x00400000, add_b=4 -> add_sum=0x00400004 the same cycle; 0xFFFFFFFC+4 -> 0.
